// File: rtl/bmu_pkg.sv
// Shared types and helpers for the pipelined branch-metric unit.
package bmu_pkg;

  // Hypothesis code: bit1 = expected I bit, bit0 = expected Q bit.
  typedef logic [1:0] hyp_t;

  localparam hyp_t HYP_00 = 2'b00;
  localparam hyp_t HYP_01 = 2'b01;
  localparam hyp_t HYP_10 = 2'b10;
  localparam hyp_t HYP_11 = 2'b11;

  // Metric selection, carried with each pair through the pipe.
  typedef enum logic {
    MET_L2 = 1'b0,
    MET_L1 = 1'b1
  } met_mode_e;

  // Largest soft value for a given width (strong '1').
  function automatic int soft_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/bmu_lane.sv
// One hypothesis lane: stage-1 distance registers, stage-2 metric register.
module bmu_lane
  import bmu_pkg::*;
#(
  parameter hyp_t EXP_OBS_OUT = HYP_00,
  parameter int   SOFT_W      = 8,
  parameter int   MET_W       = 20
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              en_a,
  input  logic              en_b,
  input  logic [SOFT_W-1:0] x_i,
  input  logic [SOFT_W-1:0] x_q,
  input  logic              erase_i,
  input  logic              erase_q,
  input  logic              mode_l1,
  output logic [MET_W-1:0]  met
);

  localparam logic [SOFT_W-1:0] MAX = SOFT_W'(soft_max(SOFT_W));

  logic [SOFT_W-1:0] di_d, di_q, dq_d, dq_q;
  met_mode_e         mode_d, mode_q;
  logic [MET_W-1:0]  met_d, met_q;
  logic [MET_W-1:0]  di_w, dq_w;

  // Stage-1 distance per lane; an erased symbol contributes nothing.
  always_comb begin
    di_d   = EXP_OBS_OUT[1] ? (MAX - x_i) : x_i;
    dq_d   = EXP_OBS_OUT[0] ? (MAX - x_q) : x_q;
    mode_d = met_mode_e'(mode_l1);
    if (erase_i) di_d = '0;
    if (erase_q) dq_d = '0;
  end

  // Stage-2 metric from registered distances, widened before the math.
  always_comb begin
    di_w  = MET_W'(di_q);
    dq_w  = MET_W'(dq_q);
    met_d = (mode_q == MET_L1) ? (di_w + dq_w) : (di_w * di_w + dq_w * dq_w);
  end

  // Pipeline registers; each stage loads only when the top advances it.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      di_q   <= '0;
      dq_q   <= '0;
      mode_q <= MET_L2;
      met_q  <= '0;
    end else begin
      if (en_a) begin
        di_q   <= di_d;
        dq_q   <= dq_d;
        mode_q <= mode_d;
      end
      if (en_b) met_q <= met_d;
    end
  end

  assign met = met_q;

endmodule

// File: rtl/bmu_pipe.sv
// Pipelined branch-metric unit: four hypothesis lanes, two-stage valid/ready pipe,
// delivered-symbol counter.
//
// Handshake: a pair transfers on s_valid && s_ready, metrics on m_valid && m_ready.
// Valid must not depend on ready; s_ready is combinational from downstream ready
// (no skid buffer): advB = !vB || m_ready, advA = !vA || advB, s_ready = advA.
module bmu_pipe
  import bmu_pkg::*;
#(
  parameter int SOFT_W  = 8,
  parameter int MET_W   = 20,
  parameter int TWOS_IN = 0,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SOFT_W-1:0]  in_i,
  input  logic [SOFT_W-1:0]  in_q,
  input  logic               erase_i,
  input  logic               erase_q,
  input  logic               mode_l1,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [4*MET_W-1:0] met_out,
  output logic [CNT_W-1:0]   sym_count
);

  generate
    if (MET_W < 2 * SOFT_W + 1) begin : g_bad_met_w
      $error("bmu_pipe: MET_W must be at least 2*SOFT_W+1");
    end
  endgenerate

  localparam logic [SOFT_W-1:0] MSB_MASK = {1'b1, {(SOFT_W-1){1'b0}}};

  logic              va_d, va_q, vb_d, vb_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              adv_a, adv_b, en_a, en_b;
  logic [SOFT_W-1:0] x_i, x_q;

  // Two's complement inputs become offset binary by flipping the sign bit.
  always_comb begin
    x_i = (TWOS_IN != 0) ? (in_i ^ MSB_MASK) : in_i;
    x_q = (TWOS_IN != 0) ? (in_q ^ MSB_MASK) : in_q;
  end

  // Stage advance, valid propagation and delivered-symbol count.
  always_comb begin
    adv_b = !vb_q || m_ready;
    adv_a = !va_q || adv_b;
    en_a  = adv_a && s_valid;
    en_b  = adv_b && va_q;
    va_d  = adv_a ? s_valid : va_q;
    vb_d  = adv_b ? va_q : vb_q;
    cnt_d = (vb_q && m_ready) ? (cnt_q + CNT_W'(1)) : cnt_q;
  end

  // Valid bits and counter; in-flight pairs are dropped on reset.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      va_q  <= 1'b0;
      vb_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      va_q  <= va_d;
      vb_q  <= vb_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar h = 0; h < 4; h++) begin : g_lane
    bmu_lane #(
      .EXP_OBS_OUT (hyp_t'(h)),
      .SOFT_W      (SOFT_W),
      .MET_W       (MET_W)
    ) u_lane (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .en_a      (en_a),
      .en_b      (en_b),
      .x_i       (x_i),
      .x_q       (x_q),
      .erase_i   (erase_i),
      .erase_q   (erase_q),
      .mode_l1   (mode_l1),
      .met       (met_out[h*MET_W +: MET_W])
    );
  end

  assign s_ready   = adv_a;
  assign m_valid   = vb_q;
  assign sym_count = cnt_q;

endmodule

// File: tb/tb_bmu_pipe.sv
// Directed bench for bmu_pipe: offset-binary instance plus a two's-complement instance.
module tb_bmu_pipe;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  in_i = '0, in_q = '0;
  logic        erase_i = 1'b0, erase_q = 1'b0, mode_l1 = 1'b0;
  logic        m_ready = 1'b1;

  logic        s_ready, m_valid, s_ready2, m_valid2;
  logic [79:0] met_out, met_out2;
  logic [31:0] sym_count, sym_count2;

  int errors = 0;
  int checks = 0;

  logic [79:0] exp_q[$];

  always #5 clk = ~clk;

  bmu_pipe #(.SOFT_W(8), .MET_W(20), .TWOS_IN(0), .CNT_W(32)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .in_i(in_i), .in_q(in_q), .erase_i(erase_i), .erase_q(erase_q), .mode_l1(mode_l1),
    .m_valid(m_valid), .m_ready(m_ready), .met_out(met_out), .sym_count(sym_count)
  );

  bmu_pipe #(.SOFT_W(8), .MET_W(20), .TWOS_IN(1), .CNT_W(32)) dut_twos (
    .clk(clk), .sys_rst_n(sys_rst_n), .s_valid(s_valid), .s_ready(s_ready2),
    .in_i(in_i), .in_q(in_q), .erase_i(erase_i), .erase_q(erase_q), .mode_l1(mode_l1),
    .m_valid(m_valid2), .m_ready(m_ready), .met_out(met_out2), .sym_count(sym_count2)
  );

  // Reference metric vector {m11,m10,m01,m00} for the offset-binary instance.
  function automatic logic [79:0] ref_vec(input logic [7:0] i, input logic [7:0] q,
                                          input logic ei, input logic eq, input logic l1);
    logic [79:0] v;
    int di, dq;
    v = '0;
    for (int h = 0; h < 4; h++) begin
      di = (h >= 2) ? 255 - int'(i) : int'(i);
      dq = (h % 2 == 1) ? 255 - int'(q) : int'(q);
      if (ei) di = 0;
      if (eq) dq = 0;
      v[h*20 +: 20] = l1 ? 20'(di + dq) : 20'(di * di + dq * dq);
    end
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b1; erase_i = 1'b0; erase_q = 1'b0; mode_l1 = 1'b0;
    sys_rst_n = 1'b0;
    @(negedge clk);
    sys_rst_n = 1'b1;
  endtask

  // Present one pair and hold it until accepted; returns on the negedge after capture.
  task automatic send_pair(input logic [7:0] i, input logic [7:0] q,
                           input logic ei, input logic eq, input logic l1);
    int n;
    n = 0;
    @(negedge clk);
    in_i = i; in_q = q; erase_i = ei; erase_q = eq; mode_l1 = l1; s_valid = 1'b1;
    #1;
    while (!s_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || met_out !== '0 || sym_count !== '0) begin
      errors++;
      $display("FAIL reset_state: m_valid=%0b met=%h cnt=%0d required 0/0/0",
               m_valid, met_out, sym_count);
    end
    @(negedge clk);
    sys_rst_n = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready: got %0b required 1", s_ready);
    end
  endtask

  task automatic test_l2_basic();
    send_pair(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || met_out !== {20'd130050, 20'd65025, 20'd65025, 20'd0}) begin
      errors++;
      $display("FAIL l2_zero: m_valid=%0b met=%h", m_valid, met_out);
    end
    @(negedge clk);
    checks++;
    if (sym_count !== 32'd1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL l2_count: cnt=%0d m_valid=%0b required 1/0", sym_count, m_valid);
    end
    checks++;
    if (met_out !== {20'd130050, 20'd65025, 20'd65025, 20'd0}) begin
      errors++; $display("FAIL bubble_hold: met=%h", met_out);
    end
  endtask

  task automatic test_l1();
    send_pair(8'h10, 8'hF0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || met_out !== {20'd254, 20'd479, 20'd31, 20'd256}) begin
      errors++;
      $display("FAIL l1_metrics: m_valid=%0b met=%h", m_valid, met_out);
    end
  endtask

  task automatic test_erasure();
    send_pair(8'h80, 8'h37, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || met_out !== {20'd16129, 20'd16129, 20'd16384, 20'd16384}) begin
      errors++;
      $display("FAIL erase_q: m_valid=%0b met=%h", m_valid, met_out);
    end
    send_pair(8'h5A, 8'hC3, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || met_out !== '0) begin
      errors++;
      $display("FAIL erase_both: m_valid=%0b met=%h required all 0", m_valid, met_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ti[5], tq[5];
    logic        tei[5], teq[5], tl1[5];
    logic [79:0] held, exp_v;
    int sent, got;
    logic prev_stall, low_seen;
    ti  = '{8'h10, 8'h00, 8'h80, 8'hFF, 8'h33};
    tq  = '{8'hF0, 8'h00, 8'h37, 8'h01, 8'hCC};
    tei = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    teq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tl1 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    exp_q.delete();
    sent = 0; got = 0; prev_stall = 1'b0; low_seen = 1'b0; held = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      m_ready = !(c >= 3 && c <= 5);
      if (sent < 5) begin
        in_i = ti[sent]; in_q = tq[sent]; erase_i = tei[sent]; erase_q = teq[sent];
        mode_l1 = tl1[sent]; s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || met_out !== held) begin
          errors++;
          $display("FAIL stall_hold: m_valid=%0b met=%h required 1/%h", m_valid, met_out, held);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: met=%h with nothing expected", met_out);
        end else begin
          exp_v = exp_q.pop_front();
          if (met_out !== exp_v) begin
            errors++; $display("FAIL stream_order: got %h required %h", met_out, exp_v);
          end
        end
        got++;
      end
      if (s_valid && !s_ready) low_seen = 1'b1;
      if (s_valid && s_ready) begin
        exp_q.push_back(ref_vec(ti[sent], tq[sent], tei[sent], teq[sent], tl1[sent]));
        sent++;
      end
      prev_stall = m_valid && !m_ready;
      held = met_out;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    checks++;
    if (got != 5) begin
      errors++; $display("FAIL stream_delivered: got %0d required 5", got);
    end
    checks++;
    if (!low_seen) begin
      errors++; $display("FAIL stream_s_ready: s_ready never dropped, required low when full");
    end
    @(negedge clk); #1;
    checks++;
    if (sym_count !== 32'd5) begin
      errors++; $display("FAIL stream_count: cnt=%0d required 5", sym_count);
    end
  endtask

  task automatic test_twos();
    send_pair(8'h80, 8'h7F, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (m_valid2 !== 1'b1 || met_out2 !== {20'd65025, 20'd130050, 20'd0, 20'd65025}) begin
      errors++;
      $display("FAIL twos_in: m_valid=%0b met=%h", m_valid2, met_out2);
    end
  endtask

  task automatic test_reset_midstream();
    logic stale;
    @(negedge clk);
    in_i = 8'h21; in_q = 8'h43; erase_i = 1'b0; erase_q = 1'b0; mode_l1 = 1'b0;
    s_valid = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    in_i = 8'h65; in_q = 8'h87;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b1 || sym_count === 32'd0) begin
      errors++;
      $display("FAIL midreset_inflight: m_valid=%0b cnt=%0d required 1/nonzero", m_valid, sym_count);
    end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || sym_count !== '0 || met_out !== '0) begin
      errors++;
      $display("FAIL midreset_clear: m_valid=%0b cnt=%0d met=%h", m_valid, sym_count, met_out);
    end
    @(negedge clk);
    sys_rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (m_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale || sym_count !== '0) begin
      errors++;
      $display("FAIL midreset_stale: stale=%0b cnt=%0d required 0/0", stale, sym_count);
    end
  endtask

  initial begin
    test_reset();
    test_l2_basic();
    test_l1();
    test_erasure();
    test_back_to_back();
    test_twos();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
